// File: rtl/gate_unit.sv
// rtl/gate_unit.sv - bitwise gate unit with 2-entry result buffer; GATE_CNT_EN adds handshake counter
module gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             c_all,
    output logic             c_any
`ifdef GATE_CNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int EW = WIDTH + 2;

    // Each entry packs {c_any, c_all, c}
    logic [EW-1:0]    buf_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic             in_ready_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] res;

    always_comb begin
        res = a;
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = ~(a & b);
            3'b100:  res = ~(a | b);
            3'b101:  res = ~(a ^ b);
            3'b110:  res = ~a;
            default: res = a;
        endcase
    end

    assign push = in_valid && in_ready_q;
    assign pop  = (occ != 2'd0) && out_ready;

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + 2'd1;
        else if (!push && pop)
            occ_next = occ - 2'd1;
    end

    // in_ready is a register so it never follows out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= {|res, &res, res};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ        <= occ_next;
            in_ready_q <= (occ_next != 2'd2);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ != 2'd0);
    assign c         = buf_q[rd_ptr][WIDTH-1:0];
    assign c_all     = buf_q[rd_ptr][WIDTH];
    assign c_any     = buf_q[rd_ptr][WIDTH+1];

`ifdef GATE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (pop)
            count <= count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_gate_unit.sv
// tb/tb_gate_unit.sv - scoreboard bench for gate_unit (WIDTH=8, CNT_W=4)
module tb_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic       c_all;
    logic       c_any;
`ifdef GATE_CNT_EN
    logic [3:0] count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] sb[$];
    int cnt_exp = 0;

    gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_all     (c_all),
        .c_any     (c_any)
`ifdef GATE_CNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        logic [7:0] r;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x & y);
            3'd4: r = ~(x | y);
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            default: r = x;
        endcase
        return {(r != 8'h00), (r == 8'hFF), r};
    endfunction

    // Called mid-cycle with inputs already driven; advances one clock
    task automatic cycle();
        logic acc;
        logic del;
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, sb.size() < 2);
`ifdef GATE_CNT_EN
        check("count", count, 4'(cnt_exp));
`endif
        if (sb.size() != 0) begin
            check("c", c, sb[0][7:0]);
            check("c_all", c_all, sb[0][8]);
            check("c_any", c_any, sb[0][9]);
        end
        acc = in_valid && (sb.size() < 2);
        del = out_ready && (sb.size() != 0);
        if (del) begin
            void'(sb.pop_front());
            cnt_exp = (cnt_exp + 1) % 16;
        end
        if (acc)
            sb.push_back(model(a, b, op));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_c", c, 8'h00);
        check("rst_c_all", c_all, 1'b0);
        check("rst_c_any", c_any, 1'b0);
`ifdef GATE_CNT_EN
        check("rst_count", count, 4'd0);
`endif
        sb.delete();
        cnt_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_pre_edge", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_post_edge", in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        op        = 3'd0;
        do_reset();

        // op sweep
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 8'hF0; b = 8'hCC; op = 3'(i); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // reductions
        a = 8'hFF; b = 8'hFF; op = 3'd0; in_valid = 1'b1;
        cycle();
        a = 8'h00;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // backpressure: third set must be refused, head held stable
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'(8'h11 * (i + 1)); b = 8'h5A; op = 3'(i + 1); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle();

        // streaming
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // reset mid-operation with two results buffered
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 8'h3C + 8'(i); b = 8'hA5; op = 3'd2; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #2;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle();

`ifdef GATE_CNT_EN
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("count_wrap", count, 4'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
